// File: rtl/serial_frame_rx.sv
// Receiver for the b13 serial transmitter: finds the one-cycle start pulse, samples
// eight MSB-first data bits and a stop bit, and parks good bytes in a one-entry holding register.
module serial_frame_rx #(
  parameter int DELAY_TIME = 104,
  parameter int BIT_PERIOD = DELAY_TIME + 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       dsr,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       idx, idx_next;
  logic [7:0]       shreg, shreg_next;
  logic             stop_done;
  logic             stop_ok;

  // Frame sequencing: the line is only looked at on the start edge and on the
  // sample points; lows anywhere else inside a frame are ignored.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    stop_done  = 1'b0;
    stop_ok    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!serial_in) state_next = DATA;
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_next = {shreg[6:0], serial_in};
          cnt_next   = '0;
          idx_next   = idx + 4'd1;
          if (idx == 4'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          stop_done  = 1'b1;
          stop_ok    = serial_in;
          cnt_next   = '0;
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  // Host handshake: data_valid=1 means data_out holds an unread byte; a one-cycle
  // rd pops it. dsr=~data_valid tells the transmitter the register is free.
  // A good frame arriving while full (and not popped that same cycle) is dropped
  // and flagged in overrun until the next pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else if (stop_done && stop_ok) begin
      frame_error <= 1'b0;
      if (!data_valid || rd) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        if (rd) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else begin
      if (stop_done) frame_error <= 1'b1;
      if (rd && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  assign dsr       = ~data_valid;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: drives transmitter-style frames and checks
// the holding register, flags and handshake against a reference model and expected-byte queue.
module tb_serial_frame_rx;

  localparam int BP = 106;

  logic       clock;
  logic       reset_n;
  logic       serial_in;
  logic       rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       dsr;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ferr;
  logic       m_ovr;

  serial_frame_rx #(.DELAY_TIME(104)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .dsr        (dsr),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".data_valid"}, {7'd0, data_valid}, {7'd0, m_valid});
    check({tag, ".dsr"}, {7'd0, dsr}, {7'd0, ~m_valid});
    check({tag, ".frame_error"}, {7'd0, frame_error}, {7'd0, m_ferr});
    check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
    check({tag, ".data_out"}, data_out, m_data);
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  // one bit slot: line high for BP-1 cycles (optionally one stray low), then the bit
  task automatic send_slot(input logic b, input logic glitch, input logic rd_here);
    for (int t = 0; t < BP - 1; t++) begin
      serial_in = (glitch && t == 50) ? 1'b0 : 1'b1;
      tick();
    end
    serial_in = b;
    rd = rd_here;
    tick();
    serial_in = 1'b1;
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_stop,
                            input logic glitch);
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    check("busy_after_start", {7'd0, busy}, 8'd1);
    check("state_after_start", {6'd0, state_dbg}, 8'd1);
    for (int k = 0; k < 8; k++) send_slot(b[7-k], glitch, 1'b0);
    send_slot(stop, glitch, rd_at_stop);
    check("busy_after_stop", {7'd0, busy}, 8'd0);
    // reference behaviour of the holding register at the stop sample
    if (stop) begin
      m_ferr = 1'b0;
      if (!m_valid || rd_at_stop) begin
        exp_q.push_back(b);
        m_valid = 1'b1;
        if (rd_at_stop) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      if (rd_at_stop && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    // scoreboard: a delivery must show the queued byte
    if (exp_q.size() > 0) begin
      m_data = exp_q.pop_front();
      check("delivered_byte", data_out, m_data);
    end
  endtask

  task automatic do_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    serial_in = 1'b1;
    rd        = 1'b0;
    model_reset();
    repeat (3) tick();
    check_flags("reset");
    check("reset.busy", {7'd0, busy}, 8'd0);
    check("reset.state", {6'd0, state_dbg}, 8'd0);
    reset_n = 1'b1;
    repeat ($urandom_range(2, 6)) tick();

    // single good frame, then pop
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_flags("a5");
    repeat ($urandom_range(1, 4)) tick();
    do_rd();
    check_flags("a5_rd");

    // bad stop bit, then a good frame back-to-back
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_flags("bad_stop");
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    check_flags("after_bad");
    do_rd();
    check_flags("after_bad_rd");

    // overrun: second frame dropped
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    check_flags("overrun");
    do_rd();
    check_flags("overrun_rd");

    // pop coinciding with the stop sample of a new frame
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h56, 1'b1, 1'b1, 1'b0);
    check_flags("simul");
    do_rd();
    check_flags("simul_rd");

    // stray lows between sample points must not disturb the frame
    send_frame(8'h9E, 1'b1, 1'b0, 1'b1);
    check_flags("glitch");

    // reset mid-frame while a byte is held: start + 5 bits, then reset
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    for (int k = 0; k < 5; k++) send_slot(1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_flags("mid_reset");
    check("mid_reset.busy", {7'd0, busy}, 8'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    check_flags("after_reset");
    repeat (BP * 2) tick();
    check_flags("after_reset_idle");
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
